// File: rtl/gfx_pkg.sv
// Shared graphics command definitions: opcodes, colours, FSM encoding, command payload.
package gfx_pkg;

    localparam int unsigned X_W   = 10;
    localparam int unsigned Y_W   = 9;
    localparam int unsigned ARG_W = 12;
    localparam int unsigned CMD_W = 1 + X_W + Y_W + X_W + Y_W + ARG_W;

    localparam logic OP_FILL = 1'b0;
    localparam logic OP_BLIT = 1'b1;

    localparam logic [ARG_W-1:0] COLOR_WHITE = 12'hFFF;
    localparam logic [ARG_W-1:0] COLOR_BLUE  = 12'h00F;
    localparam logic [ARG_W-1:0] COLOR_RED   = 12'hF00;

    typedef enum logic [2:0] {
        ST_SPLASH       = 3'd0,
        ST_ERASE_SPLASH = 3'd1,
        ST_PAINT_PANEL  = 3'd2,
        ST_IDLE         = 3'd3,
        ST_ERASE_FIELD  = 3'd4,
        ST_DRAW_BAR     = 3'd5,
        ST_DRAW_LANES   = 3'd6,
        ST_WAIT_LOW     = 3'd7
    } state_t;

    typedef struct packed {
        logic             opcode;
        logic [X_W-1:0]   tl_x;
        logic [Y_W-1:0]   tl_y;
        logic [X_W-1:0]   br_x;
        logic [Y_W-1:0]   br_y;
        logic [ARG_W-1:0] arg;
    } gp_cmd_t;

    // Build a command from full-width coordinates, truncating to port widths.
    function automatic gp_cmd_t make_cmd(input logic op, input int unsigned tl_x,
                                         input int unsigned tl_y, input int unsigned br_x,
                                         input int unsigned br_y, input logic [ARG_W-1:0] arg);
        gp_cmd_t c;
        c.opcode = op;
        c.tl_x   = X_W'(tl_x);
        c.tl_y   = Y_W'(tl_y);
        c.br_x   = X_W'(br_x);
        c.br_y   = Y_W'(br_y);
        c.arg    = arg;
        return c;
    endfunction

endpackage

// File: rtl/gp_cmd_issuer.sv
// Drives one graphics command: holds fields with gp_en high until finish, then pulses done.
module gp_cmd_issuer
    import gfx_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [CMD_W-1:0] i_cmd,
    input  logic             i_gp_finish,
    output logic             o_gp_en,
    output logic [CMD_W-1:0] o_cmd,
    output logic             o_done
);

    logic             r_en;
    logic             r_done;
    logic [CMD_W-1:0] r_cmd;
    logic             w_load;
    logic             w_finish_hit;

    // A new command only launches once the previous finish has dropped (also after reset).
    assign w_load       = i_start && !r_en && !r_done && !i_gp_finish;
    assign w_finish_hit = r_en && i_gp_finish;

    // Command register and handshake state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_en   <= 1'b0;
            r_done <= 1'b0;
            r_cmd  <= '0;
        end else begin
            r_done <= w_finish_hit;
            if (w_load) begin
                r_en  <= 1'b1;
                r_cmd <= i_cmd;
            end else if (w_finish_hit) begin
                r_en <= 1'b0;
            end
        end
    end

    assign o_gp_en = r_en;
    assign o_cmd   = r_cmd;
    assign o_done  = r_done;

endmodule

// File: rtl/game_scene_sequencer.sv
// Scene sequencer: boot splash/panel, then per-frame erase, note bar and lane markers.
module game_scene_sequencer
    import gfx_pkg::*;
#(
    parameter int unsigned H_RES      = 640,
    parameter int unsigned V_RES      = 480,
    parameter int unsigned PANEL_X    = 350,
    parameter int unsigned LANES      = 4,
    parameter int unsigned LEN_SHIFT  = 2,
    parameter int unsigned HIT_H      = 16,
    parameter logic [11:0] BG_COLOR   = COLOR_WHITE,
    parameter logic [11:0] BAR_COLOR  = COLOR_BLUE,
    parameter logic [11:0] LANE_COLOR = COLOR_RED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             keypress,
    input  logic             repaint,
    input  logic [15:0]      cur_note_length,
    input  logic [LANES-1:0] lane_mask,
    input  logic             gp_finish,
    output logic             gp_en,
    output logic             gp_opcode,
    output logic [9:0]       gp_tl_x,
    output logic [8:0]       gp_tl_y,
    output logic [9:0]       gp_br_x,
    output logic [8:0]       gp_br_y,
    output logic [11:0]      gp_arg,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun
);

    localparam int unsigned LANE_W = (H_RES - 1 - PANEL_X) / LANES;

    state_t           r_state;
    state_t           w_state_next;
    state_t           r_ret;
    state_t           w_ret_next;
    logic [LANES-1:0] r_mask;
    logic [15:0]      r_len;
    logic [2:0]       r_lane;
    logic             r_busy;
    logic             r_frame_done;
    logic             r_overrun;
    logic             r_repaint_d;

    logic             w_start;
    gp_cmd_t          w_cmd;
    logic [CMD_W-1:0] w_cmd_bits;
    gp_cmd_t          w_cmd_q;
    logic             w_done;
    logic [7:0]       w_mask8;
    logic             w_lane_on;
    logic             w_lane_last;
    int unsigned      w_shift;
    int unsigned      w_bar_h;
    int unsigned      w_lane_x;

    assign w_mask8     = 8'(r_mask);
    assign w_lane_on   = w_mask8[r_lane];
    assign w_lane_last = (r_lane == 3'(LANES - 1));
    assign w_shift     = 32'(r_len) >> LEN_SHIFT;
    assign w_bar_h     = (w_shift > V_RES - 1) ? V_RES - 1 : w_shift;
    assign w_lane_x    = PANEL_X + 1 + 32'(r_lane) * LANE_W;

    // State and return-state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_SPLASH;
            r_ret   <= ST_SPLASH;
        end else begin
            r_state <= w_state_next;
            r_ret   <= w_ret_next;
        end
    end

    // Next-state logic; every finished command detours through WAIT_LOW.
    always_comb begin
        w_state_next = r_state;
        w_ret_next   = r_ret;
        case (r_state)
            ST_SPLASH:       if (keypress) w_state_next = ST_ERASE_SPLASH;
            ST_ERASE_SPLASH: if (w_done) begin
                w_state_next = ST_WAIT_LOW;
                w_ret_next   = ST_PAINT_PANEL;
            end
            ST_PAINT_PANEL:  if (w_done) begin
                w_state_next = ST_WAIT_LOW;
                w_ret_next   = ST_IDLE;
            end
            ST_IDLE:         if (repaint) w_state_next = ST_ERASE_FIELD;
            ST_ERASE_FIELD:  if (w_done) begin
                w_state_next = ST_WAIT_LOW;
                w_ret_next   = ST_DRAW_BAR;
            end
            ST_DRAW_BAR: begin
                if (w_bar_h == 0) begin
                    w_state_next = ST_DRAW_LANES;
                end else if (w_done) begin
                    w_state_next = ST_WAIT_LOW;
                    w_ret_next   = ST_DRAW_LANES;
                end
            end
            ST_DRAW_LANES: begin
                if (!w_lane_on) begin
                    w_state_next = w_lane_last ? ST_IDLE : ST_DRAW_LANES;
                end else if (w_done) begin
                    w_state_next = ST_WAIT_LOW;
                    w_ret_next   = w_lane_last ? ST_IDLE : ST_DRAW_LANES;
                end
            end
            ST_WAIT_LOW:     if (!gp_finish) w_state_next = r_ret;
            default:         w_state_next = ST_SPLASH;
        endcase
    end

    // Command selection for the issuer.
    always_comb begin
        w_start = 1'b0;
        w_cmd   = '0;
        case (r_state)
            ST_ERASE_SPLASH: begin
                w_start = 1'b1;
                w_cmd   = make_cmd(OP_FILL, 0, 0, H_RES - 1, V_RES - 1, BG_COLOR);
            end
            ST_PAINT_PANEL: begin
                w_start = 1'b1;
                w_cmd   = make_cmd(OP_BLIT, 0, 0, PANEL_X, V_RES - 1, 12'h000);
            end
            ST_ERASE_FIELD: begin
                w_start = 1'b1;
                w_cmd   = make_cmd(OP_FILL, PANEL_X + 1, 0, H_RES - 1, V_RES - 1, BG_COLOR);
            end
            ST_DRAW_BAR: begin
                w_start = (w_bar_h != 0);
                w_cmd   = make_cmd(OP_FILL, 8, V_RES - 1 - w_bar_h, PANEL_X - 8, V_RES - 1,
                                   BAR_COLOR);
            end
            ST_DRAW_LANES: begin
                w_start = w_lane_on;
                w_cmd   = make_cmd(OP_FILL, w_lane_x, V_RES - HIT_H, w_lane_x + LANE_W - 1,
                                   V_RES - 1, LANE_COLOR);
            end
            default: ;
        endcase
    end

    // Frame latches, lane walk and status pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mask       <= '0;
            r_len        <= '0;
            r_lane       <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_repaint_d  <= 1'b0;
        end else begin
            r_repaint_d  <= repaint;
            r_frame_done <= 1'b0;
            r_overrun    <= repaint && !r_repaint_d && r_busy;
            if (r_state == ST_IDLE && repaint) begin
                r_mask <= lane_mask;
                r_len  <= cur_note_length;
                r_busy <= 1'b1;
                r_lane <= '0;
            end
            if (r_busy && w_state_next == ST_IDLE) begin
                r_busy       <= 1'b0;
                r_frame_done <= 1'b1;
            end
            if (r_state == ST_DRAW_LANES && (!w_lane_on || w_done) && !w_lane_last) begin
                r_lane <= r_lane + 3'd1;
            end
        end
    end

    gp_cmd_issuer u_issuer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_start),
        .i_cmd       (w_cmd),
        .i_gp_finish (gp_finish),
        .o_gp_en     (gp_en),
        .o_cmd       (w_cmd_bits),
        .o_done      (w_done)
    );

    assign w_cmd_q    = w_cmd_bits;
    assign gp_opcode  = w_cmd_q.opcode;
    assign gp_tl_x    = w_cmd_q.tl_x;
    assign gp_tl_y    = w_cmd_q.tl_y;
    assign gp_br_x    = w_cmd_q.br_x;
    assign gp_br_y    = w_cmd_q.br_y;
    assign gp_arg     = w_cmd_q.arg;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_game_scene_sequencer.sv
// Bench for game_scene_sequencer: scoreboard of expected draw commands fed by a frame model,
// a graphics-processor responder/monitor, and directed plus random frames.
module tb_game_scene_sequencer;
    import gfx_pkg::*;

    localparam int unsigned H  = 640;
    localparam int unsigned V  = 480;
    localparam int unsigned PX = 350;
    localparam int unsigned NL = 4;
    localparam int unsigned LS = 2;
    localparam int unsigned HH = 16;
    localparam int unsigned LW = (H - 1 - PX) / NL;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          keypress = 1'b0;
    logic          repaint = 1'b0;
    logic [15:0]   len = 16'd0;
    logic [NL-1:0] mask = '0;
    logic          gp_finish;
    logic          resp_fin = 1'b0;
    logic          force_fin = 1'b0;
    logic          gp_en, gp_opcode, busy, frame_done, overrun;
    logic [9:0]    gp_tl_x, gp_br_x;
    logic [8:0]    gp_tl_y, gp_br_y;
    logic [11:0]   gp_arg;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int frames_seen = 0;
    int frames_exp = 0;
    int ov_seen = 0;
    int ov_exp = 0;
    int phase = 0;
    int lat = 0;
    int dly = 0;
    int drop_cyc = 0;
    int fd_cyc = 0;
    bit resp_on = 1'b0;
    gp_cmd_t exp_q[$];

    assign gp_finish = resp_fin | force_fin;

    always #5 clk = ~clk;

    game_scene_sequencer #(
        .H_RES(H), .V_RES(V), .PANEL_X(PX), .LANES(NL), .LEN_SHIFT(LS), .HIT_H(HH),
        .BG_COLOR(12'hFFF), .BAR_COLOR(12'h00F), .LANE_COLOR(12'hF00)
    ) dut (
        .clk(clk), .rst_n(rst_n), .keypress(keypress), .repaint(repaint),
        .cur_note_length(len), .lane_mask(mask), .gp_finish(gp_finish),
        .gp_en(gp_en), .gp_opcode(gp_opcode), .gp_tl_x(gp_tl_x), .gp_tl_y(gp_tl_y),
        .gp_br_x(gp_br_x), .gp_br_y(gp_br_y), .gp_arg(gp_arg),
        .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic gp_cmd_t mk(input logic op, input int unsigned x0, input int unsigned y0,
                                   input int unsigned x1, input int unsigned y1,
                                   input logic [11:0] a);
        gp_cmd_t c;
        c.opcode = op;
        c.tl_x = 10'(x0);
        c.tl_y = 9'(y0);
        c.br_x = 10'(x1);
        c.br_y = 9'(y1);
        c.arg = a;
        return c;
    endfunction

    // Reference: what the screen needs for one frame, in drawing order.
    task automatic model_frame(input logic [15:0] l, input logic [NL-1:0] m);
        int unsigned h;
        h = 32'(l) / (1 << LS);
        if (h > V - 1) h = V - 1;
        exp_q.push_back(mk(1'b0, PX + 1, 0, H - 1, V - 1, 12'hFFF));
        if (h != 0) exp_q.push_back(mk(1'b0, 8, V - 1 - h, PX - 8, V - 1, 12'h00F));
        for (int i = 0; i < NL; i++)
            if (m[i]) exp_q.push_back(mk(1'b0, PX + 1 + i * LW, V - HH, PX + (i + 1) * LW,
                                         V - 1, 12'hF00));
        frames_exp++;
    endtask

    task automatic model_boot();
        exp_q.push_back(mk(1'b0, 0, 0, H - 1, V - 1, 12'hFFF));
        exp_q.push_back(mk(1'b1, 0, 0, PX, V - 1, 12'h000));
    endtask

    // Responder (3-cycle finish latency) and scoreboard monitor.
    initial begin
        gp_cmd_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (frame_done) begin frames_seen++; fd_cyc = cyc; end
            if (overrun) ov_seen++;
            if (!rst_n) begin
                resp_fin = 1'b0;
                phase = 0;
            end else if (resp_on) begin
                if (phase == 1) begin
                    lat++;
                    if (lat == 3) begin resp_fin = 1'b1; phase = 2; end
                end
                if (phase == 2 && !gp_en) begin
                    dly = $urandom_range(1, 3);
                    phase = 3;
                end
                if (phase == 3) begin
                    if (dly == 0) begin resp_fin = 1'b0; drop_cyc = cyc; phase = 0; end
                    else dly--;
                end
                if (phase == 0 && gp_en) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL cmd: unexpected op=%0d (%0d,%0d)-(%0d,%0d) arg=%h",
                                 gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.opcode !== gp_opcode || e.tl_x !== gp_tl_x || e.tl_y !== gp_tl_y ||
                            e.br_x !== gp_br_x || e.br_y !== gp_br_y || e.arg !== gp_arg) begin
                            n_fail++;
                            $display("FAIL cmd: got op=%0d (%0d,%0d)-(%0d,%0d) arg=%h expected op=%0d (%0d,%0d)-(%0d,%0d) arg=%h",
                                     gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg,
                                     e.opcode, e.tl_x, e.tl_y, e.br_x, e.br_y, e.arg);
                        end
                    end
                    lat = 0;
                    phase = 1;
                end
            end
        end
    end

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!(exp_q.size() == 0 && phase == 0 && frames_seen == frames_exp && !busy)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk({name, " timeout"}, 64'(n >= budget), 64'd0);
        chk({name, " frames"}, 64'(frames_seen), 64'(frames_exp));
        chk({name, " overruns"}, 64'(ov_seen), 64'(ov_exp));
        chk({name, " busy"}, 64'(busy), 64'd0);
        chk({name, " pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_frame(input string name, input logic [15:0] l, input logic [NL-1:0] m);
        model_frame(l, m);
        len = l;
        mask = m;
        repaint = 1'b1;
        @(negedge clk);
        repaint = 1'b0;
        len = 16'($urandom);
        mask = NL'($urandom);
        wait_done(name, 2000);
    endtask

    initial begin
        int n;
        int cnt;
        logic [15:0] l;
        repeat (3) @(negedge clk);
        chk("rst gp_en", 64'(gp_en), 64'd0);
        chk("rst fields", 64'({gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg}), 64'd0);
        chk("rst status", 64'({busy, frame_done, overrun}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Splash ignores repaint; boot sequence follows the key.
        repaint = 1'b1;
        @(negedge clk);
        repaint = 1'b0;
        repeat (10) @(negedge clk);
        chk("splash idle", 64'(gp_en), 64'd0);
        model_boot();
        resp_on = 1'b1;
        keypress = 1'b1;
        @(negedge clk);
        keypress = 1'b0;
        wait_done("boot", 500);

        run_frame("f0101", 16'd400, 4'b0101);
        run_frame("empty", 16'd0, 4'b0000);
        chk("skip latency", 64'(fd_cyc - drop_cyc), 64'(2 + NL));
        run_frame("sat", 16'hFFFF, 4'b1000);

        // Repaint pulse while lanes are drawing.
        model_frame(16'd100, 4'b1111);
        len = 16'd100;
        mask = 4'b1111;
        repaint = 1'b1;
        @(negedge clk);
        repaint = 1'b0;
        n = 0;
        while (!(gp_en && gp_tl_y == 9'(V - HH)) && n < 500) begin @(negedge clk); n++; end
        chk("lane wait timeout", 64'(n >= 500), 64'd0);
        chk("busy mid", 64'(busy), 64'd1);
        repaint = 1'b1;
        ov_exp++;
        @(negedge clk);
        repaint = 1'b0;
        wait_done("overrun", 2000);

        // Repaint held high: back-to-back frames, second one relatched.
        model_frame(16'd60, 4'b0011);
        model_frame(16'd3, 4'b1100);
        len = 16'd60;
        mask = 4'b0011;
        repaint = 1'b1;
        @(negedge clk);
        len = 16'd3;
        mask = 4'b1100;
        cnt = 0;
        n = 0;
        while (cnt < 2 && n < 2000) begin
            @(negedge clk);
            n++;
            if (frame_done) cnt++;
        end
        repaint = 1'b0;
        wait_done("held", 2000);

        // Reset mid-command with finish stuck high.
        resp_on = 1'b0;
        len = 16'd200;
        mask = 4'b0001;
        repaint = 1'b1;
        @(negedge clk);
        repaint = 1'b0;
        n = 0;
        while (!gp_en && n < 100) begin @(negedge clk); n++; end
        chk("rst cmd timeout", 64'(n >= 100), 64'd0);
        force_fin = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst gp_en", 64'(gp_en), 64'd0);
        chk("midrst busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        keypress = 1'b1;
        @(negedge clk);
        keypress = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (gp_en) cnt++;
        end
        chk("stuck finish hold", 64'(cnt), 64'd0);
        model_boot();
        resp_on = 1'b1;
        force_fin = 1'b0;
        wait_done("reboot", 500);

        // Random frames.
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 7))
                0, 1:    l = 16'd0;
                2:       l = 16'hFFFF;
                default: l = 16'($urandom_range(0, 3000));
            endcase
            run_frame("rand", l, NL'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_scene_sequencer.md
GAME_SCENE_SEQUENCER -- requirements
Module: game_scene_sequencer

Interface
REQ-001 Parameter H_RES, default 640, screen width in pixels.
REQ-002 Parameter V_RES, default 480, screen height in pixels.
REQ-003 Parameter PANEL_X, default 350, last x column of the left panel; the play field is PANEL_X+1..H_RES-1.
REQ-004 Parameter LANES, default 4, range 1..8, number of note lanes in the play field.
REQ-005 Parameter LEN_SHIFT, default 2, right shift applied to cur_note_length to get bar height.
REQ-006 Parameters HIT_H (default 16), BG_COLOR (default 12'hFFF), BAR_COLOR (default 12'h00F) and LANE_COLOR (default 12'hF00), 12-bit RGB.
REQ-007 clk, input, 1, the single clock.
REQ-008 rst_n, input, 1, synchronous, active-low reset.
REQ-009 keypress, input, 1, single-cycle key event.
REQ-010 repaint, input, 1, frame-start request, sampled as a level.
REQ-011 cur_note_length, input, 16, length of the current note.
REQ-012 lane_mask, input, LANES, active lanes, latched at frame start.
REQ-013 gp_finish, input, 1, graphics processor completion of the current command.
REQ-014 gp_en, output, 1, command valid.
REQ-015 Command fields, all outputs: gp_opcode (1 bit; 0 = fill, 1 = image blit), gp_tl_x (10 bits), gp_tl_y (9 bits), gp_br_x (10 bits), gp_br_y (9 bits), gp_arg (12 bits, colour or image id).
REQ-016 Status outputs: busy (1 bit), frame_done (1-cycle pulse), overrun (1-cycle pulse).

Function
REQ-017 States: SPLASH, ERASE_SPLASH, PAINT_PANEL, IDLE, ERASE_FIELD, DRAW_BAR, DRAW_LANES, WAIT_LOW.
REQ-018 Command handshake:
- Each command: gp_en=1 with all fields stable until gp_finish is sampled 1.
- Next cycle: gp_en=0.
- Then wait in WAIT_LOW until gp_finish=0 before the next command or state.
REQ-019 SPLASH: keypress=1 moves to ERASE_SPLASH; all other inputs are ignored.
REQ-020 ERASE_SPLASH issues fill (0,0)-(H_RES-1,V_RES-1) with arg BG_COLOR, then goes to PAINT_PANEL.
REQ-021 PAINT_PANEL issues blit (0,0)-(PANEL_X,V_RES-1) with arg 0, then goes to IDLE.
REQ-022 IDLE with repaint=1 latches lane_mask and cur_note_length, asserts busy, and goes to ERASE_FIELD.
REQ-023 ERASE_FIELD issues fill (PANEL_X+1,0)-(H_RES-1,V_RES-1) with arg BG_COLOR.
REQ-024 DRAW_BAR bar height:
- h = min(len_latched >> LEN_SHIFT, V_RES-1).
- h=0: no command is issued; go straight to DRAW_LANES.
- Otherwise issue fill (8, V_RES-1-h)-(PANEL_X-8, V_RES-1) with arg BAR_COLOR.
REQ-025 DRAW_LANES lane geometry:
- LANE_W = (H_RES-1-PANEL_X)/LANES, truncated.
- Lane i: tl_x = PANEL_X+1+i*LANE_W, br_x = tl_x+LANE_W-1.
- y range V_RES-HIT_H..V_RES-1, arg LANE_COLOR.
REQ-026 DRAW_LANES iteration:
- Lanes are visited in order 0..LANES-1.
- A lane whose latched mask bit is 0 is skipped in exactly one cycle with no command.
REQ-027 After the last lane: frame_done pulses for one cycle, busy=0, and the state returns to IDLE.
REQ-028 repaint=1 in any state other than IDLE, SPLASH or the boot states produces a one-cycle overrun pulse on its rising edge; the request is otherwise dropped and the frame in progress is unaffected.
REQ-029 repaint held high through frame end starts the next frame immediately from IDLE.
REQ-030 Coordinates are computed at full width and then truncated to port width; parameters are restricted so that results fit.

Reset
REQ-031 rst_n=0 at a clock edge forces SPLASH, including mid-command.
REQ-032 Reset values: gp_en=0, all command fields 0, busy=0, frame_done=0, overrun=0, lane latch 0, lane index 0.
REQ-033 An in-flight graphics command is abandoned on reset; the first post-reset command waits for gp_finish=0.

Structure
REQ-034 A shared package gfx_pkg holds the opcode constants (OP_FILL=0, OP_BLIT=1), the colour constants and the state encoding.
REQ-035 Sub-module gp_cmd_issuer implements the REQ-018 handshake: load fields, gp_en, done pulse. The FSM only selects fields.

Verification
REQ-036 Reset, keypress, then a responder with 3-cycle finish latency: fills (0,0,639,479,FFF) then blit (0,0,350,479,0); ends in IDLE, busy=0.
REQ-037 repaint, cur_note_length=400, lane_mask=4'b0101: commands are erase (351,0,639,479), bar (8,379,342,479,00F), lane0 (351,464,422,479), lane2 (495,464,566,479); frame_done pulses once.
REQ-038 cur_note_length=0 and lane_mask=0: only the erase command is issued; frame_done follows after 1+LANES cycles of skipping.
REQ-039 cur_note_length=16'hFFFF: bar tl_y=0 (h saturates to 479).
REQ-040 repaint pulse during DRAW_LANES: exactly one overrun pulse; command sequence unchanged.
REQ-041 rst_n low while gp_en=1 and gp_finish stuck high: state is SPLASH and gp_en=0; the next command is not issued until gp_finish drops.
